// File: rtl/sl_transmitter_fifo_if.sv
// Register bus and SL line bundle for the transmitter.
// The host drives the master side and the transmitter sits on the slave side.
interface sl_transmitter_fifo_if;
  logic [1:0]  addr;
  logic        wr_en;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        sl0;
  logic        sl1;
  logic        irq;

  modport master (output addr, wr_en, d_in, input d_out, sl0, sl1, irq);
  modport slave  (input addr, wr_en, d_in, output d_out, sl0, sl1, irq);
endinterface

// File: rtl/sl_transmitter_fifo.sv
// Two-line (SL) serial transmitter fed by a small word FIFO; first low edge 2 clk after a write to an idle block.
// Writes to a full FIFO are dropped and flagged as overflow unless a pop frees a slot in the same cycle.
module sl_transmitter_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_DIV   = 8
) (
  input logic                clk,
  input logic                rst,
  sl_transmitter_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BASE_DIV) + 6;

  typedef enum logic [3:0] {
    IDLE, LOAD, BIT_LO, BIT_HI, PAR_LO, PAR_HI, STOP_LO, STOP_HI, GAP
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [LW-1:0]     level;
  logic [5:0]        cfg_len;
  logic [2:0]        cfg_fm;
  logic              cfg_irq_en;
  logic              overflow, cfg_err;

  logic [DATA_W-1:0] sh;
  logic [5:0]        len_l, bit_idx;
  logic [2:0]        fm_l;
  logic              par;
  logic [CW-1:0]     cnt, period, half;

  logic full, empty, busy, pop, push_req, push_ok, cfg_ok, phase_end;
  logic bit_nx, sl0_nx, sl1_nx, par_calc;
  logic [DATA_W-1:0] head;

  assign full     = (level == LW'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign busy     = (state != IDLE);
  assign pop      = (state == LOAD);
  assign push_req = bus.wr_en && (bus.addr == 2'd0);
  assign push_ok  = push_req && (!full || pop);
  assign cfg_ok   = !bus.d_in[0] && (int'(bus.d_in[5:0]) >= 8) &&
                    (int'(bus.d_in[5:0]) <= DATA_W) && (bus.d_in[8:6] <= 3'd5);
  assign head     = mem[rptr];
  assign period   = CW'(BASE_DIV) << fm_l;
  assign half     = period >> 1;
  assign phase_end = (state == GAP) ? (cnt == period - CW'(1)) : (cnt == half - CW'(1));
  assign bus.irq  = cfg_irq_en && empty && !busy;

  // Odd parity over the word as it will be sent, using the length that LOAD latches.
  always_comb begin
    par_calc = 1'b1;
    for (int i = 0; i < DATA_W; i++)
      if (i < int'(cfg_len)) par_calc = par_calc ^ head[i];
  end

  always_comb begin
    bus.d_out = '0;
    case (bus.addr)
      2'd1:    bus.d_out = {22'b0, cfg_irq_en, cfg_fm, cfg_len};
      2'd2:    bus.d_out = {11'b0, cfg_err, overflow, empty, full, busy, 11'b0, 5'(level)};
      default: bus.d_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= bus.d_in[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_len    <= 6'd8;
      cfg_fm     <= 3'd0;
      cfg_irq_en <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop);
      if (push_req && !push_ok) overflow <= 1'b1;
      if (bus.wr_en && bus.addr == 2'd1) begin
        if (cfg_ok) begin
          cfg_len    <= bus.d_in[5:0];
          cfg_fm     <= bus.d_in[8:6];
          cfg_irq_en <= bus.d_in[9];
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (bus.wr_en && bus.addr == 2'd2) begin
        if (bus.d_in[19]) overflow <= 1'b0;
        if (bus.d_in[20]) cfg_err  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Line levels are decoded from the state being entered so the pins flip on the same edge as the FSM.
  always_comb begin
    state_nx = state;
    bit_nx   = sh[0];
    case (state)
      IDLE:    if (!empty) state_nx = LOAD;
      LOAD:    begin state_nx = BIT_LO; bit_nx = head[0]; end
      BIT_LO:  if (phase_end) state_nx = BIT_HI;
      BIT_HI:  if (phase_end) begin
                 if (bit_idx == len_l - 6'd1) state_nx = PAR_LO;
                 else begin state_nx = BIT_LO; bit_nx = sh[1]; end
               end
      PAR_LO:  if (phase_end) state_nx = PAR_HI;
      PAR_HI:  if (phase_end) state_nx = STOP_LO;
      STOP_LO: if (phase_end) state_nx = STOP_HI;
      STOP_HI: if (phase_end) state_nx = GAP;
      GAP:     if (phase_end) state_nx = empty ? IDLE : LOAD;
      default: state_nx = IDLE;
    endcase
    sl0_nx = 1'b1;
    sl1_nx = 1'b1;
    case (state_nx)
      BIT_LO:  begin sl0_nx = bit_nx; sl1_nx = !bit_nx; end
      PAR_LO:  begin sl0_nx = par;    sl1_nx = !par;    end
      STOP_LO: begin sl0_nx = 1'b0;   sl1_nx = 1'b0;    end
      default: begin sl0_nx = 1'b1;   sl1_nx = 1'b1;    end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      len_l   <= 6'd8;
      fm_l    <= 3'd0;
      par     <= 1'b0;
      bit_idx <= '0;
      cnt     <= '0;
      bus.sl0 <= 1'b1;
      bus.sl1 <= 1'b1;
    end else begin
      bus.sl0 <= sl0_nx;
      bus.sl1 <= sl1_nx;
      if (state == LOAD) begin
        sh      <= head;
        len_l   <= cfg_len;
        fm_l    <= cfg_fm;
        par     <= par_calc;
        bit_idx <= '0;
        cnt     <= '0;
      end else if (state == IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= phase_end ? '0 : cnt + CW'(1);
        if (state == BIT_HI && phase_end) begin
          sh      <= sh >> 1;
          bit_idx <= bit_idx + 6'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sl_transmitter_fifo.sv
// Randomised and directed bench for sl_transmitter_fifo with a line-decoding monitor.
// Expected words are queued at write time and matched against what the monitor decodes off sl0/sl1.
module tb_sl_transmitter_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sl_transmitter_fifo_if bus();
  sl_transmitter_fifo #(.DATA_W(32), .FIFO_DEPTH(4), .BASE_DIV(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { logic [31:0] w; int len; int fm; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  logic [9:0] mcfg = 10'h008;
  int low_runs = 0;

  logic [63:0] mbits;
  int  mlens [64];
  int  nb = 0;
  bit  in_run = 0;
  bit  pat_bad = 0;
  logic [1:0] run_pat, pat;
  int  run_len = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  function automatic bit cfg_valid(input logic [31:0] d);
    return !d[0] && d[5:0] >= 6'd8 && d[5:0] <= 6'd32 && d[8:6] <= 3'd5;
  endfunction

  task automatic finish_word(input int stop_len);
    exp_t e;
    logic [31:0] mask, data;
    bit wbad;
    int half;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_word got=%0d_bits expected=none", nb);
    end else begin
      e = sb.pop_front();
      mask = (e.len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << e.len) - 32'd1);
      data = '0;
      for (int i = 0; i < e.len && i < nb && i < 32; i++) data[i] = mbits[i];
      chk("word_bits", 32'(nb), 32'(e.len + 1));
      chk("word_data", data, e.w & mask);
      chk("word_parity", {31'b0, mbits[e.len]}, {31'b0, ~^(e.w & mask)});
      half = 4 << e.fm;
      wbad = (stop_len != half) || pat_bad;
      for (int i = 0; i < nb; i++) if (mlens[i] != half) wbad = 1;
      chk("word_timing", {31'b0, wbad}, 32'd0);
    end
    nb = 0;
    pat_bad = 0;
  endtask

  // Monitor: turns low pulses on the lines into symbols (0, 1 or stop) and checks whole words.
  always @(negedge clk) begin
    if (rst) begin
      nb = 0;
      in_run = 0;
      pat_bad = 0;
    end else begin
      pat = {bus.sl1, bus.sl0};
      if (pat != 2'b11) begin
        if (!in_run) begin
          in_run = 1; run_pat = pat; run_len = 1;
        end else begin
          run_len++;
          if (pat != run_pat) pat_bad = 1;
        end
      end else if (in_run) begin
        in_run = 0;
        low_runs++;
        if (run_pat == 2'b00) finish_word(run_len);
        else if (nb < 64) begin
          mbits[nb] = (run_pat == 2'b01);
          mlens[nb] = run_len;
          nb++;
        end
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a; bus.wr_en = 1'b1; bus.d_in = d;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.addr = 2'd2;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.d_out;
  endtask

  task automatic wcfg(input logic [31:0] d);
    wr(2'd1, d);
    if (cfg_valid(d)) mcfg = d[9:0];
  endtask

  task automatic send(input logic [31:0] w);
    exp_t e;
    e.w = w; e.len = int'(mcfg[5:0]); e.fm = int'(mcfg[8:6]);
    sb.push_back(e);
    wr(2'd0, w);
  endtask

  task automatic wait_idle(input int limit);
    logic [31:0] v;
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      rd(2'd2, v);
      if (v[18] && !v[16]) break;
    end
    if (i >= limit) begin
      checks++; failures++;
      $display("FAIL idle_timeout got=busy expected=idle_within_%0d", limit);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, d;
    logic [31:0] bad_cfg [6];
    int k, base, n;
    bus.addr = 2'd0; bus.wr_en = 1'b0; bus.d_in = '0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Asynchronous reset pulse
    #2 rst = 1'b1;
    #1;
    chk("reset_lines", {30'b0, bus.sl1, bus.sl0}, 32'd3);
    chk("reset_irq", {31'b0, bus.irq}, 32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    mcfg = 10'h008;
    rd(2'd2, v); chk("reset_status", v, 32'h0004_0000);
    rd(2'd1, v); chk("reset_config", v, 32'h0000_0008);
    rd(2'd0, v); chk("data_reads_zero", v, 32'd0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, v); chk("addr3_reads_zero", v, 32'd0);
    rd(2'd1, v); chk("addr3_write_no_effect", v, 32'h0000_0008);

    // 0xA5 at default timing, irq enabled
    wcfg(32'h208);
    rd(2'd2, v); chk("irq_idle", {31'b0, bus.irq}, 32'd1);
    send(32'hA5);
    @(posedge clk); #1 chk("latency_e1_high", {30'b0, bus.sl1, bus.sl0}, 32'd3);
    @(posedge clk); #1 chk("latency_e2_sl1_low", {30'b0, bus.sl1, bus.sl0}, 32'd1);
    chk("irq_busy", {31'b0, bus.irq}, 32'd0);
    k = 0;
    while ({bus.sl1, bus.sl0} != 2'b00 && k < 2000) begin @(negedge clk); k++; end
    while ({bus.sl1, bus.sl0} == 2'b00 && k < 2000) begin @(negedge clk); k++; end
    k = 0;
    do begin
      @(negedge clk); k++;
      rd(2'd2, v);
    end while (v[16] && k < 100);
    chk("busy_fall_after_stop", 32'(k), 32'd12);
    chk("irq_after_word", {31'b0, bus.irq}, 32'd1);
    chk("a5_drained", 32'(sb.size()), 32'd0);

    // Six back-to-back words into a depth-4 FIFO
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      if (i < 5) send(d);
      else wr(2'd0, d);
    end
    rd(2'd2, v); chk("burst6_status", v, 32'h000B_0004);
    wait_idle(5000);
    chk("burst6_drained", 32'(sb.size()), 32'd0);
    wr(2'd2, 32'h0008_0000);
    rd(2'd2, v); chk("overflow_cleared", v, 32'h0004_0000);

    // Illegal configurations
    bad_cfg = '{32'h207, 32'h188, 32'h222, 32'h206, 32'h209, 32'h1C8};
    foreach (bad_cfg[i]) begin
      wcfg(bad_cfg[i]);
      rd(2'd1, v); chk("bad_cfg_unchanged", v, {22'b0, mcfg});
      rd(2'd2, v); chk("cfg_err_set", v, 32'h0014_0000);
      wr(2'd2, 32'h0010_0000);
      rd(2'd2, v); chk("cfg_err_cleared", v, 32'h0004_0000);
    end

    // Config change while a word is on the line applies to the next word only
    wcfg(32'h008);
    send(32'h5A3C);
    base = low_runs; k = 0;
    while (low_runs == base && k < 500) begin @(negedge clk); #1; k++; end
    wcfg(32'h04C);
    send(32'h0ABC);
    wait_idle(5000);
    chk("cfg_change_drained", 32'(sb.size()), 32'd0);

    // Longest word at slowest rate
    wcfg(32'h160);
    send(32'hFFFF_FFFF);
    wait_idle(20000);
    chk("long_word_drained", 32'(sb.size()), 32'd0);

    // Reset during bit 3
    wcfg(32'h008);
    send(32'h0000_003C);
    base = low_runs; k = 0;
    while (!((low_runs - base) >= 3 && {bus.sl1, bus.sl0} != 2'b11) && k < 500) begin
      @(negedge clk); #1; k++;
    end
    #2 rst = 1'b1;
    #1 chk("midword_reset_lines", {30'b0, bus.sl1, bus.sl0}, 32'd3);
    sb.delete();
    @(negedge clk); @(negedge clk); rst = 1'b0;
    mcfg = 10'h008;
    rd(2'd2, v); chk("midword_reset_status", v, 32'h0004_0000);
    base = low_runs;
    repeat (200) @(negedge clk);
    #1 chk("no_resend_after_reset", 32'(low_runs), 32'(base));

    // Random bursts with random (sometimes illegal) configurations
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        d = '0;
        d[5:0] = 6'($urandom_range(6, 34));
        d[8:6] = ($urandom_range(0, 7) == 0) ? 3'd6 : 3'($urandom_range(0, 1));
        d[9]   = 1'($urandom_range(0, 1));
        wcfg(d);
        rd(2'd1, v); chk("rand_cfg", v, {22'b0, mcfg});
        rd(2'd2, v); chk("rand_cfg_err", v, cfg_valid(d) ? 32'h0004_0000 : 32'h0014_0000);
        wr(2'd2, 32'h0010_0000);
      end
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) send($urandom);
      wait_idle(20000);
      chk("rand_drained", 32'(sb.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sl_transmitter_fifo.md
SL_TRANSMITTER_FIFO -- requirements
Module: sl_transmitter_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning maximum word length in bits (even, 8..32).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO depth in words (power of 2, 2..16).
REQ-003 The block SHALL have parameter BASE_DIV, default 8, meaning clk cycles per bit period at freq_mode 0 (even, >=4).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 addr  input  2  register select: 0 data, 1 config, 2 status, 3 reserved.
REQ-007 wr_en  input  1  write strobe, sampled on the rising edge of clk.
REQ-008 d_in  input  32  write data.
REQ-009 d_out  output  32  combinational read data for the current addr.
REQ-010 sl0  output  1  SL line 0, idle high.
REQ-011 sl1  output  1  SL line 1, idle high.
REQ-012 irq  output  1  level interrupt: irq_en & FIFO empty & ~busy.

Function
REQ-013 Writing addr 0 SHALL push d_in[DATA_W-1:0] into the FIFO. The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the push is dropped and sticky overflow is set.
REQ-014 Config register (addr 1) fields SHALL be: [5:0] length, [8:6] freq_mode, [9] irq_en. A write with an odd length, a length outside 8..DATA_W, or freq_mode >5 SHALL be ignored entirely and SHALL set sticky cfg_err.
REQ-015 Status (addr 2) fields SHALL be: [4:0] fifo level, [16] busy, [17] full, [18] empty, [19] overflow, [20] cfg_err. Writing addr 2 with d_in[19] or d_in[20] set SHALL clear the corresponding sticky bit.
REQ-016 Reads of addr 0 and addr 3 SHALL return 0. Writes to addr 3 SHALL have no effect.
REQ-017 Bit period SHALL be T = BASE_DIV << freq_mode cycles. Each period SHALL consist of a low phase of T/2 cycles followed by a high phase of T/2 cycles.
REQ-018 Data bit encoding: a 0 SHALL drive sl0 low during the low phase; a 1 SHALL drive sl1 low during the low phase. Both lines SHALL be high during the high phase.
REQ-019 Each word SHALL be sent as: length data bits LSB first, then one odd-parity bit (parity = ~^data[length-1:0]) with the same encoding, then a stop period with both lines low for T/2 and high for T/2.
REQ-020 FSM states SHALL be IDLE, LOAD, BIT_LO, BIT_HI, PAR_LO, PAR_HI, STOP_LO, STOP_HI, GAP.
REQ-021 IDLE -> LOAD when the FIFO is non-empty. LOAD pops the FIFO and latches the word, length and freq_mode, then goes to BIT_LO.
REQ-022 BIT_LO -> BIT_HI -> next BIT_LO, or -> PAR_LO after the last bit. PAR_LO -> PAR_HI -> STOP_LO -> STOP_HI -> GAP. GAP holds both lines high for T cycles, then -> LOAD if the FIFO is non-empty, else -> IDLE.
REQ-023 Latency: after a write to addr 0 into an empty FIFO while in IDLE, the first sl low edge SHALL appear 2 clk cycles after the write edge.
REQ-024 A config change during a word SHALL take effect from the next LOAD only.
REQ-025 busy SHALL be high in every state except IDLE.
REQ-026 sl0 and sl1 SHALL be registered outputs and SHALL never be low simultaneously except in STOP_LO.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Level SHALL range 0..FIFO_DEPTH, and a simultaneous push and pop SHALL leave the level unchanged.

Reset
REQ-028 While rst is high: sl0=sl1=1, irq=0, FIFO emptied, FSM=IDLE, sticky bits cleared, config = length 8, freq_mode 0, irq_en 0 (config reads 0x008). Outputs SHALL change without waiting for clk.
REQ-029 Reset asserted mid-word SHALL abort the word. The word SHALL NOT be resent after reset is released.

Verification
REQ-030 Reset check: pulse rst -> sl0=sl1=1; status=0x00040000; config reads 0x008; irq=0.
REQ-031 Default config, write 0xA5 to addr 0 -> pulse lines in order sl1,sl0,sl1,sl0,sl0,sl1,sl0,sl1; parity on sl1; stop with both low 4 cycles; each low phase 4 cycles; busy falls 8 cycles after the stop ends.
REQ-032 Write 6 words back-to-back at default config -> word 1 popped, words 2-5 queued (full=1), word 6 dropped with overflow=1; exactly 5 words transmitted in order.
REQ-033 Config length 32, freq_mode 5; send 0xFFFFFFFF -> 33 sl1 pulses of 128 low cycles each, including parity=1; sl0 never low before the stop.
REQ-034 Config write with length 7 -> cfg_err=1 and config unchanged. Write 0x100000 to addr 2 -> cfg_err=0.
REQ-035 Assert rst during bit 3 of a word -> sl0=sl1=1 in the same cycle; after release, empty=1 and no further pulses.
